// File: rtl/action_arbiter.sv
// -----------------------------------------------------------------------------
// action_arbiter
// Grants one of two player action requests and presents the granted action
// for HOLD_CYCLES cycles, followed by a COOLDOWN_CYCLES idle gap.
//
// Build option:
//   ACTION_ARB_P0_PRIORITY_EN  defined   -> fixed priority, player 0 wins ties
//                              undefined -> round-robin between the players
//
// Parameters:
//   HOLD_CYCLES      cycles a granted action is presented (1..255)
//   COOLDOWN_CYCLES  idle cycles after each action (0..255)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   p0_req     in   player 0 request (level, held until p0_ack)
//   p0_act     in   player 0 action code
//   p1_req     in   player 1 request (level, held until p1_ack)
//   p1_act     in   player 1 action code
//   p0_ack     out  one-cycle grant pulse for player 0
//   p1_ack     out  one-cycle grant pulse for player 1
//   act_valid  out  high while the granted action is presented
//   act_code   out  presented action code, Run (100) when not valid
//   act_owner  out  owner of the current / last presented action
//   busy       out  high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module action_arbiter #(
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p0_req,
    input  logic [2:0] p0_act,
    input  logic       p1_req,
    input  logic [2:0] p1_act,
    output logic       p0_ack,
    output logic       p1_ack,
    output logic       act_valid,
    output logic [2:0] act_code,
    output logic       act_owner,
    output logic       busy
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned CODE_W   = 3;
    localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  COOL_LD = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CODE_W-1:0] CODE_RUN = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                p0_ack_q;
    logic                p1_ack_q;
    logic                act_valid_q;
    logic [CODE_W-1:0]   act_code_q;
    logic                act_owner_q;
    logic                busy_q;

    // Grant decision for the current IDLE evaluation
    logic                win_owner_d;
    logic [CODE_W-1:0]   win_code_d;

`ifndef ACTION_ARB_P0_PRIORITY_EN
    // Round-robin pointer: the player granted most recently
    logic                last_q;
`endif

    // Winner selection: a lone requester always wins; ties go by build option
    always_comb begin
        win_owner_d = 1'b0;
        if (p0_req && p1_req) begin
`ifdef ACTION_ARB_P0_PRIORITY_EN
            win_owner_d = 1'b0;
`else
            win_owner_d = ~last_q;
`endif
        end else if (p1_req) begin
            win_owner_d = 1'b1;
        end
    end

    // Illegal codes (101..111) are still granted but presented as Run
    always_comb begin
        win_code_d = win_owner_d ? p1_act : p0_act;
        if (win_code_d > CODE_RUN) begin
            win_code_d = CODE_RUN;
        end
    end

    // State machine with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            act_valid_q <= 1'b0;
            act_code_q  <= CODE_RUN;
            act_owner_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef ACTION_ARB_P0_PRIORITY_EN
            last_q      <= 1'b1;
`endif
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        state_q     <= ST_HOLD;
                        cnt_q       <= HOLD_LD;
                        act_valid_q <= 1'b1;
                        act_code_q  <= win_code_d;
                        act_owner_q <= win_owner_d;
                        busy_q      <= 1'b1;
                        p0_ack_q    <= ~win_owner_d;
                        p1_ack_q    <= win_owner_d;
`ifndef ACTION_ARB_P0_PRIORITY_EN
                        last_q      <= win_owner_d;
`endif
                    end
                end
                ST_HOLD: begin
                    // Counter holds the cycles left including the current one
                    if (cnt_q <= 8'd1) begin
                        act_valid_q <= 1'b0;
                        act_code_q  <= CODE_RUN;
                        if (COOL_LD != 8'd0) begin
                            state_q <= ST_COOL;
                            cnt_q   <= COOL_LD;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_COOL: begin
                    if (cnt_q <= 8'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    act_valid_q <= 1'b0;
                    act_code_q  <= CODE_RUN;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign act_valid = act_valid_q;
    assign act_code  = act_code_q;
    assign act_owner = act_owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_action_arbiter.sv
// -----------------------------------------------------------------------------
// tb_action_arbiter
// Directed and randomized checks of action_arbiter against a timeline model:
// each grant is an edge number, presentation and busy windows follow from it.
// A second instance (HOLD_CYCLES=1, COOLDOWN_CYCLES=0) covers back-to-back
// grants.
// -----------------------------------------------------------------------------
module tb_action_arbiter;

    localparam int H = 4;
    localparam int C = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       p0_req = 1'b0, p1_req = 1'b0;
    logic [2:0] p0_act = 3'd0, p1_act = 3'd0;
    logic       p0_ack, p1_ack, act_valid, act_owner, busy;
    logic [2:0] act_code;

    logic       d2_req = 1'b0;
    logic [2:0] d2_act = 3'd0;
    logic       d2_p0_ack, d2_p1_ack, d2_valid, d2_owner, d2_busy;
    logic [2:0] d2_code;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    action_arbiter #(.HOLD_CYCLES(H), .COOLDOWN_CYCLES(C)) u_dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_act(p0_act),
        .p1_req(p1_req), .p1_act(p1_act),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .act_valid(act_valid), .act_code(act_code),
        .act_owner(act_owner), .busy(busy)
    );

    action_arbiter #(.HOLD_CYCLES(1), .COOLDOWN_CYCLES(0)) u_dut2 (
        .clock(clock), .reset(reset),
        .p0_req(d2_req), .p0_act(d2_act),
        .p1_req(1'b0), .p1_act(3'd0),
        .p0_ack(d2_p0_ack), .p1_ack(d2_p1_ack),
        .act_valid(d2_valid), .act_code(d2_code),
        .act_owner(d2_owner), .busy(d2_busy)
    );

    // Timeline model: edge index, last grant edge, first edge a grant may occur
    int   t = 0;
    int   g_edge = -1000;
    int   nxt_free = 0;
    bit   last_w = 1'b1;
    bit   m_owner = 1'b0;
    logic [2:0] g_code = 3'd4;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_edge(input bit rst, input bit r0, input logic [2:0] a0,
                              input bit r1, input logic [2:0] a1);
        bit w;
        t++;
        if (rst) begin
            g_edge   = -1000;
            nxt_free = t + 1;
            last_w   = 1'b1;
            m_owner  = 1'b0;
        end else if (t >= nxt_free && (r0 || r1)) begin
            if (r0 && r1) begin
`ifdef ACTION_ARB_P0_PRIORITY_EN
                w = 1'b0;
`else
                w = ~last_w;
`endif
            end else begin
                w = r1;
            end
            g_edge   = t;
            g_code   = w ? a1 : a0;
            m_owner  = w;
            last_w   = w;
            nxt_free = t + H + C + 1;
        end
    endtask

    task automatic check_all();
        bit   e_valid;
        logic [2:0] e_code;
        e_valid = (t - g_edge) < H;
        e_code  = !e_valid ? 3'd4 : (g_code > 3'd4 ? 3'd4 : g_code);
        check("p0_ack",    8'(p0_ack),    8'((t == g_edge) && !m_owner));
        check("p1_ack",    8'(p1_ack),    8'((t == g_edge) && m_owner));
        check("act_valid", 8'(act_valid), 8'(e_valid));
        check("act_code",  8'(act_code),  8'(e_code));
        check("act_owner", 8'(act_owner), 8'(m_owner));
        check("busy",      8'(busy),      8'(t < nxt_free - 1));
    endtask

    task automatic step(input bit rst, input bit r0, input logic [2:0] a0,
                        input bit r1, input logic [2:0] a1);
        reset  = rst;
        p0_req = r0; p0_act = a0;
        p1_req = r1; p1_act = a1;
        @(posedge clock);
        model_edge(rst, r0, a0, r1, a1);
        #1;
        check_all();
    endtask

    initial begin
        bit         r0, r1, rst;
        logic [2:0] a0, a1;
        bit         exp_v;

        // Reset values
        step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        check("rst_code", 8'(act_code), 8'h04);

        // Single requester p0, Punch: grant one cycle later, 4 hold, 2 cool
        step(1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
        check("first_grant_code", 8'(act_code), 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        // Illegal code from p1 presented as Run
        step(1'b0, 1'b0, 3'd0, 1'b1, 3'd6);
        check("illegal_owner", 8'(act_owner), 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        // Both held: alternating grants every H+C+1 cycles
        for (int i = 0; i < 3 * (H + C + 1); i++) step(1'b0, 1'b1, 3'd0, 1'b1, 3'd3);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        // Grant p0, reset in the second hold cycle, then a tie goes to p0
        step(1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd4, 1'b1, 3'd1);
        check("tie_after_reset", 8'(p0_ack), 8'h01);

        // p1 pulse during hold dropped before idle: no grant
        step(1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
        step(1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        // Back-to-back instance: valid and ack every other cycle
        d2_req = 1'b1; d2_act = 3'd2;
        step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            exp_v = (i % 2) == 0;
            check("d2_valid", 8'(d2_valid),  8'(exp_v));
            check("d2_ack",   8'(d2_p0_ack), 8'(exp_v));
            check("d2_code",  8'(d2_code),   exp_v ? 8'h02 : 8'h04);
        end
        d2_req = 1'b0;

        // Randomized: requests held until acked, occasional drops and resets
        r0 = 1'b0; r1 = 1'b0; a0 = 3'd0; a1 = 3'd0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (r0 && t == g_edge && !m_owner) r0 = 1'b0;
            else if (!r0 && $urandom_range(0, 3) == 0) begin
                r0 = 1'b1; a0 = 3'($urandom_range(0, 7));
            end else if (r0 && $urandom_range(0, 24) == 0) r0 = 1'b0;
            if (r1 && t == g_edge && m_owner) r1 = 1'b0;
            else if (!r1 && $urandom_range(0, 3) == 0) begin
                r1 = 1'b1; a1 = 3'($urandom_range(0, 7));
            end else if (r1 && $urandom_range(0, 24) == 0) r1 = 1'b0;
            step(rst, r0, a0, r1, a1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/action_arbiter.md
ACTION_ARBITER -- requirements
Module: action_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a granted action is presented (legal 1..255).
REQ-002 Parameter COOLDOWN_CYCLES, default 2, idle gap after each action (legal 0..255).
REQ-003 clock  input  1  rising-edge clock; all state updates on posedge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 p0_req  input  1  player 0 action request; level, held until p0_ack.
REQ-006 p0_act  input  3  player 0 action code (Kick=000, Punch=001, Jump=010, Duck=011, Run=100).
REQ-007 p1_req  input  1  player 1 action request; level, held until p1_ack.
REQ-008 p1_act  input  3  player 1 action code, same encoding.
REQ-009 p0_ack  output  1  one-cycle pulse: player 0 request granted.
REQ-010 p1_ack  output  1  one-cycle pulse: player 1 request granted.
REQ-011 act_valid  output  1  high while the granted action is presented.
REQ-012 act_code  output  3  presented action code; Run (100) when act_valid low.
REQ-013 act_owner  output  1  player owning act_code (0 or 1); holds last owner when idle.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States IDLE, HOLD, COOL; all outputs registered.
REQ-016 IDLE: if p0_req or p1_req high at an edge, next state HOLD; else stay IDLE.
REQ-017 On the IDLE->HOLD edge: latch winner's code into act_code, set act_valid=1, act_owner=winner, pulse winner's ack for exactly one cycle.
REQ-018 Grant latency: request sampled at edge N -> act_valid and ack high after edge N (same cycle).
REQ-019 Arbitration (default build): round-robin; single requester always wins; on simultaneous requests the player not granted last wins.
REQ-020 Round-robin pointer updates only on a grant, to the winner.
REQ-021 HOLD lasts exactly HOLD_CYCLES cycles; act_code and act_owner constant throughout; input changes ignored.
REQ-022 HOLD exit: to COOL if COOLDOWN_CYCLES>0, else directly to IDLE; act_valid=0, act_code=100 on exit.
REQ-023 COOL lasts exactly COOLDOWN_CYCLES cycles, act_valid=0, then IDLE.
REQ-024 Minimum grant-to-grant spacing = HOLD_CYCLES+COOLDOWN_CYCLES+1 cycles (IDLE costs one cycle).
REQ-025 Illegal codes 101..111 are granted and acked but presented as Run (100).
REQ-026 Requests arriving in HOLD/COOL are not acked until the next IDLE evaluation; a req still high then is a new request.
REQ-027 Duration counter 8 bits, loaded on state entry, counts down; no wrap-around.
REQ-028 Ack never asserted for a player whose req is low at the granting edge; never both acks in one cycle.

Reset
REQ-029 reset at any edge, including mid-HOLD or mid-COOL, overrides all: state=IDLE, counter=0.
REQ-030 Reset values: p0_ack=0, p1_ack=0, act_valid=0, act_code=100, act_owner=0, busy=0.
REQ-031 Reset sets round-robin pointer to "player 1 last", so player 0 wins the first tie.
REQ-032 No grant occurs on the edge where reset is high.

Configuration
REQ-033 Macro ACTION_ARB_P0_PRIORITY_EN: when defined, arbitration is fixed priority, player 0 always wins ties, pointer unused.
REQ-034 Without ACTION_ARB_P0_PRIORITY_EN, round-robin per REQ-019/020; all other behaviour identical in both builds.

Verification
REQ-035 Reset, p0_req=1 p0_act=001 -> 1 cycle later p0_ack pulse, act_valid=1 act_code=001 owner=0 for 4 cycles, then 2 cycles act_valid=0 code=100, busy low after.
REQ-036 Both req held high, p0_act=000 p1_act=011 -> grants alternate p0,p1,p0 every 7 cycles (default params); priority build: p0 every grant.
REQ-037 p1_req with p1_act=110 -> p1_ack pulse, act_code=100, owner=1.
REQ-038 reset asserted in 2nd HOLD cycle -> next cycle all outputs at REQ-030 values; next tie goes to p0.
REQ-039 COOLDOWN_CYCLES=0, HOLD_CYCLES=1, p0_req held -> act_valid high 1 cycle of every 2, ack each grant.
REQ-040 p1_req pulsed during HOLD and dropped before IDLE -> no p1_ack, no grant.
